// File: rtl/udp_arp_rx.sv
// Receive-side frame parser: answers ARP requests for local_ip with a one-cycle pulse,
// and forwards matching IPv4/UDP payload cut-through after a single length beat.
module udp_arp_rx #(
  parameter logic [47:0] local_mac  = 48'h00_0a_35_01_02_03,
  parameter logic [31:0] local_ip   = 32'h10_00_00_80,
  parameter logic [15:0] local_port = 16'h04d2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_fifo_tvalid,
  output logic        rx_fifo_tready,
  input  logic [7:0]  rx_fifo_tdata,
  input  logic        rx_fifo_tlast,
  input  logic        rx_fifo_tuser,
  output logic        arp_dv_out,
  output logic [47:0] remote_mac,
  output logic [31:0] remote_ip,
  output logic        udp_tvalid,
  input  logic        udp_tready,
  output logic [7:0]  udp_tdata,
  output logic        udp_tlast,
  output logic        udp_tuser,
  output logic        length_tvalid,
  input  logic        length_tready,
  output logic [15:0] length_tdata
);

  typedef enum logic [2:0] {
    S_HDR, S_CHK1, S_CHK2, S_ARPEND, S_LEN, S_PAY, S_FORCE, S_DROP
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_byte_cnt;
  logic [7:0]  r_hdr [0:41];
  logic        r_tlast_seen;
  logic        r_err;
  logic [19:0] r_csum;
  logic        r_arp_ok;
  logic        r_udp_ok;
  logic [15:0] r_len;
  logic [15:0] r_pay_cnt;
  logic        r_arp_dv;
  logic [47:0] r_remote_mac;
  logic [31:0] r_remote_ip;

  logic        w_rx_hs;
  logic        w_hdr_entry;
  logic [47:0] w_dst_mac;
  logic [15:0] w_etype;
  logic [15:0] w_w14;
  logic [15:0] w_w16;
  logic [15:0] w_w20;
  logic [31:0] w_ip38;
  logic [31:0] w_ip30;
  logic [15:0] w_dport;
  logic [15:0] w_udp_len;
  logic [15:0] w_ip_word [0:9];
  logic [19:0] w_csum_sum;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;
  logic        w_csum_ok;
  logic        w_arp_fields;
  logic        w_udp_fields;
  logic        w_arp_end;
  logic        w_arp_err;
  logic        w_pay_last;
  logic        w_trunc;

  assign w_rx_hs   = rx_fifo_tvalid & rx_fifo_tready;

  assign w_dst_mac = {r_hdr[0], r_hdr[1], r_hdr[2], r_hdr[3], r_hdr[4], r_hdr[5]};
  assign w_etype   = {r_hdr[12], r_hdr[13]};
  assign w_w14     = {r_hdr[14], r_hdr[15]};
  assign w_w16     = {r_hdr[16], r_hdr[17]};
  assign w_w20     = {r_hdr[20], r_hdr[21]};
  assign w_ip30    = {r_hdr[30], r_hdr[31], r_hdr[32], r_hdr[33]};
  assign w_ip38    = {r_hdr[38], r_hdr[39], r_hdr[40], r_hdr[41]};
  assign w_dport   = {r_hdr[36], r_hdr[37]};
  assign w_udp_len = {r_hdr[38], r_hdr[39]};

  // IPv4 header words, bytes 14..33
  for (genvar gi = 0; gi < 10; gi++) begin : g_ip_word
    assign w_ip_word[gi] = {r_hdr[14 + 2*gi], r_hdr[15 + 2*gi]};
  end

  always_comb begin
    w_csum_sum = '0;
    for (int i = 0; i < 10; i++) begin
      w_csum_sum = w_csum_sum + {4'd0, w_ip_word[i]};
    end
  end

  // At most 10 words, so one fold leaves a carry of 1 that cannot overflow again
  assign w_fold1   = {1'b0, r_csum[15:0]} + {13'd0, r_csum[19:16]};
  assign w_fold2   = w_fold1[15:0] + {15'd0, w_fold1[16]};
  assign w_csum_ok = (w_fold2 == 16'hFFFF);

  assign w_arp_fields = ((w_dst_mac == 48'hFFFF_FFFF_FFFF) || (w_dst_mac == local_mac)) &&
                        (w_etype == 16'h0806) && (w_w14 == 16'h0001) &&
                        (w_w16 == 16'h0800) && (r_hdr[18] == 8'h06) && (r_hdr[19] == 8'h04) &&
                        (w_w20 == 16'h0001) && (w_ip38 == local_ip);

  assign w_udp_fields = (w_dst_mac == local_mac) && (w_etype == 16'h0800) &&
                        (r_hdr[14] == 8'h45) && (r_hdr[23] == 8'h11) &&
                        ((w_w20 & 16'h3FFF) == 16'h0000) && (w_ip30 == local_ip) &&
                        (w_dport == local_port) && (w_udp_len >= 16'd9);

  assign w_arp_end  = r_tlast_seen | (w_rx_hs & rx_fifo_tlast);
  assign w_arp_err  = r_err | (w_rx_hs & rx_fifo_tuser);
  assign w_pay_last = (r_pay_cnt == r_len - 16'd1) | rx_fifo_tlast;
  assign w_trunc    = rx_fifo_tlast & (r_pay_cnt != r_len - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HDR: begin
        if (w_rx_hs) begin
          if (r_byte_cnt == 8'd41) w_state_next = S_CHK1;
          else if (rx_fifo_tlast)  w_state_next = S_HDR;
        end
      end
      S_CHK1: w_state_next = S_CHK2;
      S_CHK2: begin
        if (r_arp_ok)                   w_state_next = S_ARPEND;
        else if (r_udp_ok && w_csum_ok) w_state_next = S_LEN;
        else if (r_tlast_seen)          w_state_next = S_HDR;
        else                            w_state_next = S_DROP;
      end
      S_ARPEND: if (w_arp_end) w_state_next = S_HDR;
      S_LEN:    if (length_tready) w_state_next = r_tlast_seen ? S_FORCE : S_PAY;
      S_PAY: begin
        if (w_rx_hs && w_pay_last) w_state_next = rx_fifo_tlast ? S_HDR : S_DROP;
      end
      S_FORCE:  if (udp_tready) w_state_next = S_HDR;
      S_DROP:   if (w_rx_hs && rx_fifo_tlast) w_state_next = S_HDR;
      default:  w_state_next = S_HDR;
    endcase
  end

  always_comb begin
    rx_fifo_tready = 1'b0;
    udp_tvalid     = 1'b0;
    udp_tdata      = 8'd0;
    udp_tlast      = 1'b0;
    udp_tuser      = 1'b0;
    length_tvalid  = 1'b0;
    length_tdata   = 16'd0;
    case (r_state)
      S_HDR, S_DROP: rx_fifo_tready = 1'b1;
      S_ARPEND:      rx_fifo_tready = ~r_tlast_seen;
      S_LEN: begin
        length_tvalid = 1'b1;
        length_tdata  = r_len;
      end
      S_PAY: begin
        rx_fifo_tready = udp_tready;
        udp_tvalid     = rx_fifo_tvalid;
        udp_tdata      = rx_fifo_tdata;
        udp_tlast      = w_pay_last;
        udp_tuser      = w_pay_last & (rx_fifo_tuser | w_trunc);
      end
      S_FORCE: begin
        udp_tvalid = 1'b1;
        udp_tlast  = 1'b1;
        udp_tuser  = 1'b1;
      end
      default: ;
    endcase
    // The FIFO shares rst; nothing is accepted while it is held
    if (rst) rx_fifo_tready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (r_state == S_HDR && w_rx_hs) begin
      r_hdr[r_byte_cnt[5:0]] <= rx_fifo_tdata;
    end
  end

  assign w_hdr_entry = (w_state_next == S_HDR) &&
                       ((r_state != S_HDR) || (w_rx_hs && rx_fifo_tlast));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt   <= 8'd0;
      r_tlast_seen <= 1'b0;
      r_err        <= 1'b0;
      r_csum       <= 20'd0;
      r_arp_ok     <= 1'b0;
      r_udp_ok     <= 1'b0;
      r_len        <= 16'd0;
      r_pay_cnt    <= 16'd0;
      r_arp_dv     <= 1'b0;
      r_remote_mac <= 48'd0;
      r_remote_ip  <= 32'd0;
    end else begin
      if (w_hdr_entry)                          r_byte_cnt <= 8'd0;
      else if (w_rx_hs && r_byte_cnt != 8'hFF)  r_byte_cnt <= r_byte_cnt + 8'd1;

      if (r_state == S_HDR && w_rx_hs && r_byte_cnt == 8'd41) begin
        r_tlast_seen <= rx_fifo_tlast;
        r_err        <= rx_fifo_tuser;
      end else if (r_state == S_ARPEND && w_rx_hs) begin
        r_err <= r_err | rx_fifo_tuser;
      end

      if (r_state == S_CHK1) begin
        r_csum   <= w_csum_sum;
        r_arp_ok <= w_arp_fields;
        r_udp_ok <= w_udp_fields;
        r_len    <= w_udp_len - 16'd8;
      end

      if (r_state == S_LEN)               r_pay_cnt <= 16'd0;
      else if (r_state == S_PAY && w_rx_hs) r_pay_cnt <= r_pay_cnt + 16'd1;

      r_arp_dv <= (r_state == S_ARPEND) && w_arp_end && !w_arp_err;
      if ((r_state == S_ARPEND) && w_arp_end && !w_arp_err) begin
        r_remote_mac <= {r_hdr[22], r_hdr[23], r_hdr[24], r_hdr[25], r_hdr[26], r_hdr[27]};
        r_remote_ip  <= {r_hdr[28], r_hdr[29], r_hdr[30], r_hdr[31]};
      end
    end
  end

  assign arp_dv_out = r_arp_dv;
  assign remote_mac = r_remote_mac;
  assign remote_ip  = r_remote_ip;

endmodule

// File: tb/tb_udp_arp_rx.sv
// Bench for udp_arp_rx: directed and random frames checked against a frame-level model.
module tb_udp_arp_rx;

  localparam logic [47:0] LMAC  = 48'h000a35010203;
  localparam logic [31:0] LIP   = 32'h10000080;
  localparam logic [15:0] LPORT = 16'h04d2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_fifo_tvalid;
  logic        rx_fifo_tready;
  logic [7:0]  rx_fifo_tdata;
  logic        rx_fifo_tlast;
  logic        rx_fifo_tuser;
  logic        arp_dv_out;
  logic [47:0] remote_mac;
  logic [31:0] remote_ip;
  logic        udp_tvalid;
  logic        udp_tready;
  logic [7:0]  udp_tdata;
  logic        udp_tlast;
  logic        udp_tuser;
  logic        length_tvalid;
  logic        length_tready;
  logic [15:0] length_tdata;

  always #5 clk = ~clk;

  udp_arp_rx dut (
    .clk(clk), .rst(rst),
    .rx_fifo_tvalid(rx_fifo_tvalid), .rx_fifo_tready(rx_fifo_tready),
    .rx_fifo_tdata(rx_fifo_tdata), .rx_fifo_tlast(rx_fifo_tlast), .rx_fifo_tuser(rx_fifo_tuser),
    .arp_dv_out(arp_dv_out), .remote_mac(remote_mac), .remote_ip(remote_ip),
    .udp_tvalid(udp_tvalid), .udp_tready(udp_tready), .udp_tdata(udp_tdata),
    .udp_tlast(udp_tlast), .udp_tuser(udp_tuser),
    .length_tvalid(length_tvalid), .length_tready(length_tready), .length_tdata(length_tdata)
  );

  int compared   = 0;
  int mismatched = 0;
  int viol       = 0;
  int cyc_cnt    = 0;
  int last_hs_cyc = 0;
  int len_wait   = 0;
  bit tog        = 1'b0;

  logic [7:0]  frm[$];
  logic [7:0]  pay[$];
  logic [79:0] obs_arp[$];
  int          obs_arp_cyc[$];
  logic [15:0] obs_len[$];
  logic [9:0]  obs_pay[$];
  logic [79:0] exp_arp[$];
  logic [15:0] exp_len[$];
  logic [9:0]  exp_pay[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Output monitor plus cross-interface ordering rules
  always @(negedge clk) begin
    if (!rst) begin
      if (arp_dv_out) begin
        obs_arp.push_back({remote_mac, remote_ip});
        obs_arp_cyc.push_back(cyc_cnt);
      end
      if (length_tvalid && length_tready) obs_len.push_back(length_tdata);
      if (udp_tvalid && udp_tready) begin
        obs_pay.push_back({udp_tlast, udp_tuser, udp_tdata});
        if (obs_len.size() == 0) viol++;
      end
      if (arp_dv_out && ((length_tvalid && length_tready) || (udp_tvalid && udp_tready))) viol++;
      if (length_tvalid && rx_fifo_tready) viol++;
    end
  end

  // Sink-side ready generators
  initial begin
    udp_tready    = 1'b1;
    length_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      udp_tready = tog ? 1'($urandom_range(1)) : 1'b1;
      if (length_tvalid && len_wait > 0) begin
        length_tready = 1'b0;
        len_wait--;
      end else begin
        length_tready = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] be(input int off, input int nb);
    logic [63:0] v = '0;
    for (int k = 0; k < nb; k++) v = (v << 8) | 64'(frm[off + k]);
    return v;
  endfunction

  task automatic push_be(input logic [63:0] v, input int nb);
    for (int k = nb - 1; k >= 0; k--) frm.push_back(v[8*k +: 8]);
  endtask

  task automatic build_arp(input logic [47:0] dmac, input logic [47:0] smac,
                           input logic [31:0] sip, input logic [31:0] tip, input int total);
    frm.delete();
    push_be(64'(dmac), 6); push_be(64'(smac), 6); push_be(64'h0806, 2);
    push_be(64'h0001, 2); push_be(64'h0800, 2); push_be(64'h0604, 2); push_be(64'h0001, 2);
    push_be(64'(smac), 6); push_be(64'(sip), 4); push_be(64'd0, 6); push_be(64'(tip), 4);
    while (frm.size() < total) frm.push_back(8'h00);
  endtask

  task automatic build_udp(input logic [47:0] dmac, input logic [15:0] port, input int plen,
                           input logic [15:0] frag, input bit bad_csum, input int ulen,
                           input int total);
    logic [31:0] s;
    frm.delete();
    push_be(64'(dmac), 6); push_be(64'h020000000009, 6); push_be(64'h0800, 2);
    push_be(64'h4500, 2); push_be(64'(28 + plen), 2); push_be(64'($urandom_range(65535)), 2);
    push_be(64'(frag), 2); push_be(64'h4011, 2); push_be(64'h0000, 2);
    push_be(64'h10000005, 4); push_be(64'(LIP), 4);
    s = 32'd0;
    for (int k = 0; k < 10; k++) s = s + 32'(be(14 + 2*k, 2));
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    s = ~s & 32'hFFFF;
    if (bad_csum) s = s ^ 32'h1;
    frm[24] = s[15:8];
    frm[25] = s[7:0];
    push_be(64'h1388, 2); push_be(64'(port), 2);
    push_be(64'((ulen < 0) ? 8 + plen : ulen), 2); push_be(64'h0000, 2);
    for (int k = 0; k < plen; k++) frm.push_back(pay[k]);
    while (frm.size() < total) frm.push_back(8'h00);
  endtask

  task automatic fill_pay(input int n, input int base);
    pay.delete();
    for (int k = 0; k < n; k++) pay.push_back((base < 0) ? 8'($urandom) : 8'(base + k));
  endtask

  // Frame-level reference: what the receiver must produce for frm with tuser on tlast
  task automatic model(input bit tu);
    int n, avail, k, plen;
    logic [31:0] s;
    bit dst_local, dst_ok, arp, udp;
    exp_arp.delete(); exp_len.delete(); exp_pay.delete();
    n = frm.size();
    if (n < 42) return;
    dst_local = (be(0, 6) == 64'(LMAC));
    dst_ok    = dst_local || (be(0, 6) == 64'hFFFFFFFFFFFF);
    arp = dst_ok && be(12, 2) == 64'h0806 && be(14, 2) == 64'h0001 && be(16, 2) == 64'h0800 &&
          frm[18] == 8'h06 && frm[19] == 8'h04 && be(20, 2) == 64'h0001 && be(38, 4) == 64'(LIP);
    s = 32'd0;
    for (int j = 0; j < 10; j++) s = s + 32'(be(14 + 2*j, 2));
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    udp = dst_local && be(12, 2) == 64'h0800 && frm[14] == 8'h45 && frm[23] == 8'h11 &&
          (be(20, 2) & 64'h3FFF) == 0 && s == 32'hFFFF && be(30, 4) == 64'(LIP) &&
          be(36, 2) == 64'(LPORT) && be(38, 2) >= 9;
    if (arp && !tu) exp_arp.push_back({be(22, 6)[47:0], be(28, 4)[31:0]});
    if (udp) begin
      plen  = int'(be(38, 2)) - 8;
      avail = n - 42;
      exp_len.push_back(16'(plen));
      if (avail == 0) begin
        exp_pay.push_back({1'b1, 1'b1, 8'h00});
      end else begin
        k = (plen < avail) ? plen : avail;
        for (int j = 0; j < k; j++) begin
          exp_pay.push_back({(j == k - 1),
                             (j == k - 1) && ((tu && avail == k) || (avail < plen)),
                             frm[42 + j]});
        end
      end
    end
  endtask

  task automatic send_frame(input bit tu, input int gap, input int stop_at, output bit ok);
    int i = 0;
    int cyc = 0;
    bit hs;
    ok = 1'b1;
    while (i < frm.size() && i != stop_at) begin
      if (gap > 0 && $urandom_range(99) < gap) begin
        rx_fifo_tvalid = 1'b0;
      end else begin
        rx_fifo_tvalid = 1'b1;
        rx_fifo_tdata  = frm[i];
        rx_fifo_tlast  = (i == frm.size() - 1);
        rx_fifo_tuser  = rx_fifo_tlast & tu;
      end
      @(negedge clk);
      hs = rx_fifo_tvalid && rx_fifo_tready;
      if (hs && rx_fifo_tlast) last_hs_cyc = cyc_cnt;
      @(posedge clk);
      #1;
      if (hs) i++;
      cyc++;
      if (cyc > 3000) begin
        ok = 1'b0;
        break;
      end
    end
    if (i != stop_at) rx_fifo_tvalid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit tu, input int gap);
    bit ok;
    model(tu);
    obs_arp.delete(); obs_arp_cyc.delete(); obs_len.delete(); obs_pay.delete();
    send_frame(tu, gap, -1, ok);
    check({tag, ".consumed"}, 80'(ok), 80'(1));
    repeat (30) @(posedge clk);
    #1;
    check({tag, ".arp_n"}, 80'(obs_arp.size()), 80'(exp_arp.size()));
    for (int k = 0; k < exp_arp.size() && k < obs_arp.size(); k++)
      check({tag, ".arp"}, obs_arp[k], exp_arp[k]);
    check({tag, ".len_n"}, 80'(obs_len.size()), 80'(exp_len.size()));
    for (int k = 0; k < exp_len.size() && k < obs_len.size(); k++)
      check({tag, ".len"}, 80'(obs_len[k]), 80'(exp_len[k]));
    check({tag, ".pay_n"}, 80'(obs_pay.size()), 80'(exp_pay.size()));
    for (int k = 0; k < exp_pay.size() && k < obs_pay.size(); k++)
      check({tag, ".pay"}, 80'(obs_pay[k]), 80'(exp_pay[k]));
    $display("frame %s: %0d bytes, arp %0d, len %0d, pay %0d", tag, frm.size(),
             obs_arp.size(), obs_len.size(), obs_pay.size());
  endtask

  initial begin
    bit ok;
    int kind, plen;
    rst = 1'b1;
    rx_fifo_tvalid = 1'b0; rx_fifo_tdata = 8'h00; rx_fifo_tlast = 1'b0; rx_fifo_tuser = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.tready", 80'(rx_fifo_tready), 80'(0));
    check("rst.outs", 80'({arp_dv_out, udp_tvalid, length_tvalid, length_tdata}), 80'(0));
    check("rst.remote", {remote_mac, remote_ip}, 80'(0));
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("idle.tready", 80'(rx_fifo_tready), 80'(1));
    @(posedge clk); #1;

    build_arp(48'hFFFFFFFFFFFF, 48'h020000000001, 32'h10000005, LIP, 60);
    run_frame("arp_bcast", 1'b0, 0);
    check("arp_bcast.fixed", obs_arp.size() > 0 ? obs_arp[0] : 80'(0),
          {48'h020000000001, 32'h10000005});
    if (obs_arp_cyc.size() > 0) check("arp_bcast.latency", 80'(obs_arp_cyc[0] - last_hs_cyc), 80'(1));

    build_arp(48'hFFFFFFFFFFFF, 48'h020000000077, 32'h10000007, 32'h10000063, 60);
    run_frame("arp_other_ip", 1'b0, 0);
    build_arp(48'hFFFFFFFFFFFF, 48'h020000000077, 32'h10000007, LIP, 60);
    run_frame("arp_tuser", 1'b1, 0);
    check("arp.held", {remote_mac, remote_ip}, {48'h020000000001, 32'h10000005});
    build_arp(LMAC, 48'h02AABBCCDDEE, 32'h10000011, LIP, 60);
    run_frame("arp_unicast", 1'b0, 20);

    fill_pay(5, 11);
    build_udp(LMAC, LPORT, 5, 16'h0000, 1'b0, -1, 60);
    run_frame("udp5", 1'b0, 0);
    check("udp5.first", obs_pay.size() > 0 ? 80'(obs_pay[0]) : 80'(0), 80'({2'b00, 8'd11}));
    build_udp(LMAC, LPORT, 5, 16'h0000, 1'b1, -1, 60);
    run_frame("udp_badsum", 1'b0, 0);
    build_udp(LMAC, 16'd1235, 5, 16'h0000, 1'b0, -1, 60);
    run_frame("udp_port", 1'b0, 0);
    build_udp(LMAC, LPORT, 5, 16'h0001, 1'b0, -1, 60);
    run_frame("udp_frag", 1'b0, 0);
    build_udp(LMAC, LPORT, 5, 16'h0000, 1'b0, 8, 60);
    run_frame("udp_len8", 1'b0, 0);

    tog = 1'b1; len_wait = 10;
    fill_pay(24, -1);
    build_udp(LMAC, LPORT, 24, 16'h4000, 1'b0, -1, 66);
    run_frame("udp_bp", 1'b0, 25);
    tog = 1'b0; len_wait = 0;

    fill_pay(10, 40);
    build_udp(LMAC, LPORT, 10, 16'h0000, 1'b0, -1, 0);
    while (frm.size() > 30) void'(frm.pop_back());
    run_frame("trunc30", 1'b0, 0);
    build_arp(48'hFFFFFFFFFFFF, 48'h020000000002, 32'h10000006, LIP, 60);
    run_frame("arp_after_trunc", 1'b0, 0);

    fill_pay(3, 1);
    build_udp(LMAC, LPORT, 3, 16'h0000, 1'b0, -1, 0);
    while (frm.size() > 42) void'(frm.pop_back());
    run_frame("udp_hdr_only", 1'b0, 0);
    fill_pay(10, 60);
    build_udp(LMAC, LPORT, 10, 16'h0000, 1'b0, -1, 0);
    while (frm.size() > 46) void'(frm.pop_back());
    run_frame("udp_trunc_pay", 1'b0, 0);
    fill_pay(20, 80);
    build_udp(LMAC, LPORT, 20, 16'h0000, 1'b0, -1, 62);
    run_frame("udp_exact_tuser", 1'b1, 0);

    for (int r = 0; r < 30; r++) begin
      kind = $urandom_range(5);
      plen = $urandom_range(1, 30);
      tog  = 1'($urandom_range(1));
      len_wait = $urandom_range(3);
      fill_pay(plen, -1);
      case (kind)
        0: build_arp(($urandom_range(1) != 0) ? LMAC : 48'hFFFFFFFFFFFF,
                     {16'($urandom), 32'($urandom)}, 32'($urandom), LIP, 60);
        1: build_arp(48'hFFFFFFFFFFFF, 48'h020000000003, 32'h1000000A,
                     {24'h100000, 8'($urandom)}, 60);
        2: build_udp(LMAC, LPORT, plen, 16'h0000, 1'b0, -1, (42 + plen < 60) ? 60 : 42 + plen);
        3: build_udp(($urandom_range(1) != 0) ? LMAC : 48'h000a35010204, LPORT, plen,
                     16'($urandom_range(1) * $urandom_range(8191)),
                     1'($urandom_range(1)), -1, 60);
        4: begin
          build_udp(LMAC, LPORT, plen, 16'h0000, 1'b0, -1, 0);
          while (frm.size() > 10 + $urandom_range(31)) void'(frm.pop_back());
        end
        default: begin
          build_udp(LMAC, LPORT, plen, 16'h0000, 1'b0, -1, 0);
          while (frm.size() > 42 + $urandom_range(plen)) void'(frm.pop_back());
        end
      endcase
      run_frame($sformatf("rand%0d_k%0d", r, kind), ($urandom_range(7) == 0), $urandom_range(30));
    end
    tog = 1'b0; len_wait = 0;

    fill_pay(30, 100);
    build_udp(LMAC, LPORT, 30, 16'h0000, 1'b0, -1, 72);
    send_frame(1'b0, 0, 50, ok);
    check("midrst.reached", 80'(ok), 80'(1));
    check("midrst.streaming", 80'(udp_tvalid), 80'(1));
    #2; rst = 1'b1; #1;
    check("midrst.outs", 80'({arp_dv_out, udp_tvalid, udp_tlast, udp_tuser, udp_tdata,
                              length_tvalid, length_tdata, rx_fifo_tready}), 80'(0));
    check("midrst.remote", {remote_mac, remote_ip}, 80'(0));
    rx_fifo_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #1;
    check("midrst.hdr", 80'(rx_fifo_tready), 80'(1));
    build_arp(48'hFFFFFFFFFFFF, 48'h020000000004, 32'h10000009, LIP, 60);
    run_frame("arp_after_rst", 1'b0, 0);

    check("protocol", 80'(viol), 80'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
